// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    VALID,
    DRAIN
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, keeps one request outstanding to a variable-latency
// instruction memory and buffers the returned word for the F/D register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            fetch_busy,
  output logic            imem_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;

  assign target   = PCTargetE & ~XLEN'(3);
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state and request decode; the request path sees PCSrcE/StallF directly.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    err_d     = err_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      ISSUE: begin
        if (imem_rvalid) err_d = 1'b1;
        if (PCSrcE) begin
          pc_d = target;
        end else begin
          imem_req = !rst;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid && PCSrcE) begin
          pc_d    = target;
          state_d = ISSUE;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end else if (PCSrcE) begin
          pc_d    = target;
          state_d = DRAIN;
        end
      end
      VALID: begin
        if (imem_rvalid) err_d = 1'b1;
        if (PCSrcE) begin
          imem_req  = !rst;
          imem_addr = target;
          pc_d      = target;
          state_d   = WAIT;
        end else if (!StallF) begin
          imem_req  = !rst;
          imem_addr = pc_plus4;
          pc_d      = pc_plus4;
          state_d   = WAIT;
        end
      end
      DRAIN: begin
        // The killed response must still be absorbed before a new request.
        if (PCSrcE) pc_d = target;
        if (imem_rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign instrF     = (state_q == VALID) ? instr_q : NOP_INSTR;
  assign PCF        = pc_q;
  assign PCPlus4F   = pc_plus4;
  assign fetch_busy = (state_q != VALID);
  assign imem_err   = err_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline fetch stage: owns the PC register, issues single-outstanding requests to a variable-latency instruction memory, and presents instrF/PCF/PCPlus4F to the F/D pipeline register.
- Accepts branch/jump redirects from Execute and stalls from the hazard unit.
- Asserts fetch_busy while no valid instruction is available. The hazard unit ORs fetch_busy into StallF/StallD, so a NOP never enters Decode as real work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- StallF  in  1  hold the current instruction; do not advance PC.
- PCSrcE  in  1  redirect request from Execute (taken branch/jump).
- PCTargetE  in  32  redirect target.
- imem_req  out  1  memory request strobe. Memory always accepts it in the same cycle.
- imem_addr  out  32  request address, word aligned.
- imem_rvalid  in  1  response valid. Arrives at least 1 cycle after the request.
- imem_rdata  in  32  response instruction word.
- instrF  out  32  instruction to the F/D register.
- PCF  out  32  PC of instrF.
- PCPlus4F  out  32  PCF + 4.
- fetch_busy  out  1  no valid instruction this cycle.
- imem_err  out  1  sticky protocol error flag.

Behaviour:
- States:
  - ISSUE: send a request.
  - WAIT: request outstanding.
  - VALID: instruction held in buffer.
  - DRAIN: outstanding request has been killed by a redirect.
- Registers: pc_q, instr_q, state, err_q. Outputs are decoded from these registers, except imem_req/imem_addr, which also depend combinationally on PCSrcE/StallF.
- Reset (async, rst=1):
  - state=ISSUE, pc_q=RESET_PC, instr_q=NOP (32'h0000_0013), err_q=0.
  - Outputs: instrF=NOP, PCF=RESET_PC, PCPlus4F=RESET_PC+4, fetch_busy=1, imem_req=0, imem_err=0.
- Output rules:
  - instrF = instr_q in VALID, else NOP.
  - PCF = pc_q.
  - PCPlus4F = pc_q+4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000).
  - fetch_busy = (state != VALID).
- Redirect target is PCTargetE with bits [1:0] forced to 0.
- ISSUE:
  - If PCSrcE: imem_req=0, pc_q<=target, stay in ISSUE.
  - Else: imem_req=1, imem_addr=pc_q, go to WAIT.
- WAIT, checked in this order:
  - imem_rvalid && PCSrcE: discard data, pc_q<=target, go to ISSUE.
  - imem_rvalid: instr_q<=imem_rdata, go to VALID.
  - PCSrcE: pc_q<=target, go to DRAIN.
  - Otherwise stay in WAIT. imem_req=0 throughout WAIT.
- VALID, checked in this order:
  - PCSrcE (takes priority over StallF): imem_req=1, imem_addr=target, pc_q<=target, go to WAIT.
  - !StallF: imem_req=1, imem_addr=pc_q+4, pc_q<=pc_q+4, go to WAIT.
  - StallF: hold everything. imem_req=0, and instrF/PCF stay stable for as long as the stall lasts.
- DRAIN (imem_req=0), checked in this order:
  - imem_rvalid: discard data; if PCSrcE also, pc_q<=target; go to ISSUE.
  - PCSrcE without rvalid: pc_q<=target, stay in DRAIN.
- Error: imem_rvalid in ISSUE or VALID is an unsolicited response. The data is ignored and err_q<=1 until reset.
- Throughput: minimum 2 cycles per instruction with 1-cycle memory latency (VALID -> WAIT -> VALID).
- Reset mid-request: returns to ISSUE immediately. The memory must not deliver a response after reset deasserts; the testbench enforces this.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum fetch_state_t {ISSUE, WAIT, VALID, DRAIN};
  - localparam NOP_INSTR = 32'h0000_0013;
  - the default RESET_PC value.
- No sub-module. The PC increment and target alignment are inline expressions.

Test Plan:
1. Reset then free-run with 1-cycle memory, rdata=addr|0x13: imem_addr sequence 0x0, 0x4, 0x8; instrF=0x13 at PCF=0x0, then 0x17 at PCF=0x4; fetch_busy alternates 1/0.
2. Stall: StallF=1 for 3 cycles while in VALID at PCF=0x8: instrF/PCF unchanged, imem_req=0, fetch_busy=0. After release, next imem_addr=0xC.
3. Redirect in VALID at PCF=0x8 with PCTargetE=0x103 and StallF=1: imem_addr=0x100 issued the same cycle; next valid PCF=0x100.
4. Redirect while WAIT with 4-cycle latency (PCTargetE=0x40): state goes to DRAIN; the late response is discarded (never appears on instrF); next request imem_addr=0x40; fetch_busy=1 throughout.
5. Simultaneous imem_rvalid and PCSrcE in WAIT, target 0x80: data dropped, goes to ISSUE; next cycle imem_addr=0x80.
6. Unsolicited imem_rvalid in VALID: instrF unchanged and imem_err=1 until rst. Also: rst asserted during WAIT gives PCF=RESET_PC and fetch_busy=1 asynchronously, and operation resumes from RESET_PC.
